// File: rtl/snitch_ro_cache_ctrl.sv
// Read-only cache enable/flush sequencer: drains cache-path reads before mode changes.
// Optional perf counters via SNITCH_RO_CACHE_CTRL_PERF_EN.
module snitch_ro_cache_ctrl #(
  parameter int unsigned MaxTrans = 4,
  parameter int unsigned CntWidth = $clog2(MaxTrans + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_enable_i,
  input  logic                flush_valid_i,
  output logic                flush_ready_o,
  input  logic                ar_valid_i,
  input  logic                ar_ready_i,
  input  logic                ar_cache_i,
  input  logic                r_valid_i,
  input  logic                r_ready_i,
  input  logic                r_last_i,
  output logic                ar_hold_o,
  output logic                cache_enable_o,
  output logic                cache_flush_valid_o,
  input  logic                cache_flush_ready_i,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                busy_o
`ifdef SNITCH_RO_CACHE_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_flush_cnt_o,
  output logic [31:0]         perf_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    FLUSH,
    UPDATE
  } state_e;

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTrans);

  state_e              state_q, state_d;
  logic                enable_q, enable_d;
  logic                do_flush_q, do_flush_d;
  logic                ack_q;
  logic [CntWidth-1:0] cnt_q;

  logic ar_hs, r_last_hs, ar_idle, flush_done;

  assign ar_hs      = ar_valid_i & ar_ready_i & ar_cache_i;
  assign r_last_hs  = r_valid_i & r_ready_i & r_last_i;
  assign ar_idle    = !ar_valid_i | ar_ready_i;
  assign flush_done = (state_q == FLUSH) & cache_flush_ready_i;

  always_comb begin
    state_d    = state_q;
    enable_d   = enable_q;
    do_flush_d = do_flush_q;
    unique case (state_q)
      RUN: begin
        if ((flush_valid_i | (cfg_enable_i != enable_q)) & ar_idle) begin
          state_d = DRAIN;
          if (flush_valid_i) do_flush_d = 1'b1;
        end
      end
      DRAIN: begin
        // A final beat retiring this cycle still counts as in flight.
        if ((cnt_q == '0) && !r_last_hs)
          state_d = do_flush_q ? FLUSH : UPDATE;
      end
      FLUSH: begin
        if (cache_flush_ready_i) begin
          state_d    = UPDATE;
          do_flush_d = 1'b0;
        end
      end
      UPDATE: begin
        enable_d = cfg_enable_i;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      enable_q   <= 1'b0;
      do_flush_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      do_flush_q <= do_flush_d;
      ack_q      <= flush_done;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (ar_hs && !r_last_hs && cnt_q != CntMax) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (r_last_hs && !ar_hs && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
    !(ar_hs && !r_last_hs && cnt_q == CntMax));
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(r_last_hs && !ar_hs && cnt_q == '0));

  assign ar_hold_o           = (state_q != RUN);
  assign busy_o              = (state_q != RUN);
  assign cache_enable_o      = enable_q;
  assign cache_flush_valid_o = (state_q == FLUSH);
  assign flush_ready_o       = ack_q;
  assign outstanding_o       = cnt_q;

`ifdef SNITCH_RO_CACHE_CTRL_PERF_EN
  logic [31:0] perf_flush_q, perf_stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_flush_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (flush_done) perf_flush_q <= perf_flush_q + 32'd1;
      if (ar_hold_o & ar_valid_i) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_flush_cnt_o = perf_flush_q;
  assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule
